// File: rtl/div_sched.sv
// Sequencer between EX and the iterative divider: latches operands, stalls the
// pipeline, short-circuits divide-by-zero and aborts on flush or watchdog expiry.
module div_sched #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 40,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic               signed_i,
  input  logic [WIDTH-1:0]   opa_i,
  input  logic [WIDTH-1:0]   opb_i,
  input  logic               flush_i,
  output logic               stall_o,
  output logic               div_start_o,
  output logic               div_annul_o,
  output logic               div_signed_o,
  output logic [WIDTH-1:0]   div_opa_o,
  output logic [WIDTH-1:0]   div_opb_o,
  input  logic               div_ready_i,
  input  logic [2*WIDTH-1:0] div_result_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic [1:0]         hilo_we_o,
  output logic               busy_o,
  output logic               timeout_o,
  output logic [CNT_W-1:0]   cycles_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DONE  = 2'd2,
    S_ABORT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               sgn_q, sgn_d, timeout_q, timeout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cycles_q, cycles_d;
  logic [CNT_W-1:0]   cnt_inc_s;
  logic               accept_s;
  logic               stall_s, start_s, annul_s;
  logic [1:0]         we_s;

  assign accept_s  = req_i & ~flush_i;
  assign cnt_inc_s = cnt_q + ONE_C;

  // Next-state, datapath capture and handshake outputs
  always_comb begin
    state_d   = state_q;
    opa_d     = opa_q;
    opb_d     = opb_q;
    sgn_d     = sgn_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    timeout_d = timeout_q;
    cnt_d     = cnt_q;
    cycles_d  = cycles_q;
    stall_s   = 1'b0;
    start_s   = 1'b0;
    annul_s   = 1'b0;
    we_s      = 2'b00;
    case (state_q)
      S_IDLE: begin
        stall_s = accept_s;
        if (accept_s) begin
          opa_d = opa_i;
          opb_d = opb_i;
          sgn_d = signed_i;
          cnt_d = {CNT_W{1'b0}};
          // A zero divisor never reaches the divider
          if (opb_i == {WIDTH{1'b0}}) begin
            hi_d    = opa_i;
            lo_d    = {WIDTH{1'b1}};
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        start_s = 1'b1;
        stall_s = 1'b1;
        cnt_d   = cnt_inc_s;
        if (flush_i) begin
          state_d = S_ABORT;
        end else if (div_ready_i) begin
          hi_d     = div_result_i[2*WIDTH-1:WIDTH];
          lo_d     = div_result_i[WIDTH-1:0];
          cycles_d = cnt_inc_s;
          state_d  = S_DONE;
        end else if (cnt_inc_s == TIMEOUT_C) begin
          timeout_d = 1'b1;
          state_d   = S_ABORT;
        end else begin
          state_d = S_RUN;
        end
      end
      S_DONE: begin
        we_s    = flush_i ? 2'b00 : 2'b11;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        annul_s = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      opa_q     <= {WIDTH{1'b0}};
      opb_q     <= {WIDTH{1'b0}};
      sgn_q     <= 1'b0;
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
      timeout_q <= 1'b0;
      cnt_q     <= {CNT_W{1'b0}};
      cycles_q  <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      opa_q     <= opa_d;
      opb_q     <= opb_d;
      sgn_q     <= sgn_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
      cycles_q  <= cycles_d;
    end
  end

  assign stall_o      = stall_s;
  assign div_start_o  = start_s;
  assign div_annul_o  = annul_s;
  assign hilo_we_o    = we_s;
  assign busy_o       = (state_q != S_IDLE);
  assign div_signed_o = sgn_q;
  assign div_opa_o    = opa_q;
  assign div_opb_o    = opb_q;
  assign hi_o         = hi_q;
  assign lo_o         = lo_q;
  assign timeout_o    = timeout_q;
  assign cycles_o     = cycles_q;

endmodule

// File: tb/tb_div_sched.sv
// Bench for div_sched: the bench plays EX and the divider, predicts every output
// per cycle from a transaction timeline, and compares on each falling edge.
module tb_div_sched;
  localparam int W  = 32;
  localparam int TO = 40;
  localparam int CW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_i = 1'b0, signed_i = 1'b0, flush_i = 1'b0;
  logic [W-1:0]  opa_i = '0, opb_i = '0;
  logic          stall_o, div_start_o, div_annul_o, div_signed_o;
  logic [W-1:0]  div_opa_o, div_opb_o;
  logic          div_ready_i = 1'b0;
  logic [2*W-1:0] div_result_i = '0;
  logic [W-1:0]  hi_o, lo_o;
  logic [1:0]    hilo_we_o;
  logic          busy_o, timeout_o;
  logic [CW-1:0] cycles_o;

  div_sched #(.WIDTH(W), .TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .signed_i(signed_i),
    .opa_i(opa_i), .opb_i(opb_i), .flush_i(flush_i),
    .stall_o(stall_o), .div_start_o(div_start_o), .div_annul_o(div_annul_o),
    .div_signed_o(div_signed_o), .div_opa_o(div_opa_o), .div_opb_o(div_opb_o),
    .div_ready_i(div_ready_i), .div_result_i(div_result_i),
    .hi_o(hi_o), .lo_o(lo_o), .hilo_we_o(hilo_we_o), .busy_o(busy_o),
    .timeout_o(timeout_o), .cycles_o(cycles_o)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;
  int stall_cnt = 0, start_cnt = 0, annul_cnt = 0;
  bit chk_en = 1'b0;

  // Expected combinational outputs for the current cycle
  logic e_stall = 1'b0, e_start = 1'b0, e_annul = 1'b0, e_busy = 1'b0;
  logic [1:0] e_we = 2'b00;
  // Expected architectural state
  logic [W-1:0]  m_hi = '0, m_lo = '0, m_opa = '0, m_opb = '0;
  logic [CW-1:0] m_cyc = '0;
  logic          m_to = 1'b0, m_sgn = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] golden(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W-1:0] q, r;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic ex(input logic st, input logic sr, input logic an, input logic [1:0] we, input logic bz);
    e_stall = st; e_start = sr; e_annul = an; e_we = we; e_busy = bz;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("stall",  64'(stall_o),      64'(e_stall));
      chk("start",  64'(div_start_o),  64'(e_start));
      chk("annul",  64'(div_annul_o),  64'(e_annul));
      chk("we",     64'(hilo_we_o),    64'(e_we));
      chk("busy",   64'(busy_o),       64'(e_busy));
      chk("hi",     64'(hi_o),         64'(m_hi));
      chk("lo",     64'(lo_o),         64'(m_lo));
      chk("tmo",    64'(timeout_o),    64'(m_to));
      chk("cycles", 64'(cycles_o),     64'(m_cyc));
      chk("opa",    64'(div_opa_o),    64'(m_opa));
      chk("opb",    64'(div_opb_o),    64'(m_opb));
      chk("sgn",    64'(div_signed_o), 64'(m_sgn));
      if (stall_o)     stall_cnt++;
      if (div_start_o) start_cnt++;
      if (div_annul_o) annul_cnt++;
    end
  end

  // One instruction: lat = RUN cycle the divider answers (0 = never),
  // fl = RUN cycle EX flushes (0 = never), fl_done = flush during DONE.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                         input int lat, input int fl, input bit fl_done);
    logic [63:0] g;
    int k;
    bit ended, done, tmo;
    g = (b != '0) ? golden(a, b, s) : 64'd0;
    req_i = 1'b1; opa_i = a; opb_i = b; signed_i = s; flush_i = 1'b0; div_ready_i = 1'b0;
    ex(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    m_opa = a; m_opb = b; m_sgn = s;
    opa_i = ~a; opb_i = b ^ 32'h5A5A_0001; signed_i = ~s;
    done = 1'b0; tmo = 1'b0;
    if (b == '0) begin
      m_hi = a; m_lo = '1; done = 1'b1;
    end else begin
      k = 1; ended = 1'b0;
      while (!ended) begin
        ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
        if (k == fl) begin
          flush_i = 1'b1; ended = 1'b1;
        end else if (k == lat) begin
          div_ready_i = 1'b1; div_result_i = g; ended = 1'b1; done = 1'b1;
        end else if (k == TO) begin
          ended = 1'b1; tmo = 1'b1;
        end else begin
          div_result_i = {$urandom, $urandom};
        end
        tick();
        flush_i = 1'b0; div_ready_i = 1'b0; div_result_i = {$urandom, $urandom};
        k++;
      end
      if (done) begin
        m_hi = g[63:32]; m_lo = g[31:0]; m_cyc = CW'(lat);
      end
    end
    if (done) begin
      flush_i = fl_done;
      ex(1'b0, 1'b0, 1'b0, fl_done ? 2'b00 : 2'b11, 1'b1);
      tick();
      flush_i = 1'b0;
    end else begin
      if (tmo) m_to = 1'b1;
      req_i = 1'b0;
      ex(1'b0, 1'b0, 1'b1, 2'b00, 1'b1);
      tick();
    end
    req_i = 1'b0;
    ex(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
  endtask

  initial begin
    // Golden model pinned against hand-computed results
    chk("gold_100_7",  golden(32'd100, 32'd7, 1'b1),       {32'd2, 32'd14});
    chk("gold_m7_2_s", golden(32'hFFFF_FFF9, 32'd2, 1'b1), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    chk("gold_m7_2_u", golden(32'hFFFF_FFF9, 32'd2, 1'b0), {32'd1, 32'h7FFF_FFFC});

    // Reset state
    ex(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    chk_en = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();

    // 1: signed 100/7, answer after 34 RUN cycles
    stall_cnt = 0;
    run_div(32'd100, 32'd7, 1'b1, 34, 0, 1'b0);
    chk("t1_hi", 64'(hi_o), 64'd2);
    chk("t1_lo", 64'(lo_o), 64'd14);
    chk("t1_cycles", 64'(cycles_o), 64'd34);
    chk("t1_stall_cycles", 64'(stall_cnt), 64'd35);

    // 2: signed and unsigned -7 / 2
    run_div(32'hFFFF_FFF9, 32'd2, 1'b1, 5, 0, 1'b0);
    chk("t2s_lo", 64'(lo_o), 64'hFFFF_FFFD);
    chk("t2s_hi", 64'(hi_o), 64'hFFFF_FFFF);
    run_div(32'hFFFF_FFF9, 32'd2, 1'b0, 3, 0, 1'b0);
    chk("t2u_lo", 64'(lo_o), 64'h7FFF_FFFC);
    chk("t2u_hi", 64'(hi_o), 64'd1);
    chk("t2u_sgn", 64'(div_signed_o), 64'd0);

    // 3: divide by zero never starts the divider
    start_cnt = 0;
    run_div(32'h1234_5678, 32'd0, 1'b1, 0, 0, 1'b0);
    chk("t3_starts", 64'(start_cnt), 64'd0);
    chk("t3_hi", 64'(hi_o), 64'h1234_5678);
    chk("t3_lo", 64'(lo_o), 64'hFFFF_FFFF);

    // 4: flush in RUN cycle 10
    annul_cnt = 0;
    run_div(32'd500, 32'd3, 1'b0, 20, 10, 1'b0);
    chk("t4_annul_pulses", 64'(annul_cnt), 64'd1);
    chk("t4_hi_kept", 64'(hi_o), 64'h1234_5678);
    chk("t4_lo_kept", 64'(lo_o), 64'hFFFF_FFFF);

    // 5: watchdog, then a good divide with the flag still set
    start_cnt = 0;
    run_div(32'd77, 32'd5, 1'b1, 0, 0, 1'b0);
    chk("t5_run_cycles", 64'(start_cnt), 64'd40);
    chk("t5_tmo", 64'(timeout_o), 64'd1);
    run_div(32'd50, 32'd5, 1'b0, 3, 0, 1'b0);
    chk("t5_lo_after", 64'(lo_o), 64'd10);
    chk("t5_tmo_sticky", 64'(timeout_o), 64'd1);

    // Flush during DONE suppresses the write; flush with a request in IDLE is not accepted
    run_div(32'd9, 32'd4, 1'b0, 2, 0, 1'b1);
    req_i = 1'b1; flush_i = 1'b1; opa_i = 32'd1; opb_i = 32'd1;
    ex(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    req_i = 1'b0; flush_i = 1'b0;
    tick();

    // 6: reset in RUN cycle 5
    annul_cnt = 0;
    req_i = 1'b1; opa_i = 32'd1000; opb_i = 32'd10; signed_i = 1'b0;
    ex(1'b1, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    m_opa = 32'd1000; m_opb = 32'd10; m_sgn = 1'b0;
    ex(1'b1, 1'b1, 1'b0, 2'b00, 1'b1);
    for (int k = 1; k < 5; k++) tick();
    @(negedge clk);
    #2;
    chk_en = 1'b0;
    rst = 1'b0;
    req_i = 1'b0;
    #1;
    chk("t6_busy", 64'(busy_o), 64'd0);
    chk("t6_stall", 64'(stall_o), 64'd0);
    chk("t6_start", 64'(div_start_o), 64'd0);
    chk("t6_we", 64'(hilo_we_o), 64'd0);
    chk("t6_annul", 64'(div_annul_o), 64'd0);
    chk("t6_tmo", 64'(timeout_o), 64'd0);
    chk("t6_hi", 64'(hi_o), 64'd0);
    m_hi = '0; m_lo = '0; m_opa = '0; m_opb = '0; m_cyc = '0; m_to = 1'b0; m_sgn = 1'b0;
    ex(1'b0, 1'b0, 1'b0, 2'b00, 1'b0);
    tick();
    chk("t6_annul_in_rst", 64'(div_annul_o), 64'd0);
    rst = 1'b1;
    chk_en = 1'b1;
    tick();
    run_div(32'd1000, 32'd10, 1'b0, 8, 0, 1'b0);
    chk("t6_lo_after", 64'(lo_o), 64'd100);
    chk("t6_cycles_after", 64'(cycles_o), 64'd8);
    chk("t6_no_annul", 64'(annul_cnt), 64'd0);

    chk_en = 1'b0;
    tick();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
